// File: rtl/and_or_tree_arb_pkg.sv
// Shared types and the AND-OR function for the and_or_tree_arbiter block.
package and_or_tree_arb_pkg;

    localparam int unsigned AOT_ARB_MAX_REQ = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_RESP} arb_state_t;

    function automatic logic and_or_tree(input logic x, input logic y, input logic z);
        return (x & y) | z;
    endfunction

endpackage

// File: rtl/and_or_tree_arbiter_rr_pick.sv
// Combinational grant picker: rotating priority from start when AND_OR_TREE_ARB_RR_EN,
// otherwise fixed lowest-index priority (start ignored).
module aot_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any
);

`ifdef AND_OR_TREE_ARB_RR_EN
    int idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = int'(start) + k;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_id          = ID_W'(idx);
                gnt_onehot[idx] = 1'b1;
            end
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start;

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!any && req[i]) begin
                any           = 1'b1;
                gnt_id        = ID_W'(i);
                gnt_onehot[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/and_or_tree_arbiter.sv
// Arbitrates NUM_REQ requesters onto one registered (x & y) | z unit.
// AND_OR_TREE_ARB_RR_EN selects round-robin; undefined gives fixed priority.
module and_or_tree_arbiter
    import and_or_tree_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [NUM_REQ-1:0] req_x,
    input  logic [NUM_REQ-1:0] req_y,
    input  logic [NUM_REQ-1:0] req_z,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_data,
    output logic [ID_W-1:0]    res_id,
    output logic [CNT_W-1:0]   ops_cnt
);

    arb_state_t         state_q;
    logic               x_q, y_q, z_q;
    logic               data_q;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ID_W-1:0]    start;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]    gnt_id;
    logic               any;

`ifdef AND_OR_TREE_ARB_RR_EN
    logic [ID_W-1:0] last_grant_q;

    // Search begins one past the last completed grant, wrapping at NUM_REQ.
    assign start = (last_grant_q == ID_W'(NUM_REQ - 1)) ? '0 : last_grant_q + ID_W'(1);
`else
    assign start = '0;
`endif

    aot_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (req_valid),
        .start      (start),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id),
        .any        (any)
    );

    assign req_ready = (state_q == ST_IDLE) ? gnt_onehot : '0;
    assign res_valid = (state_q == ST_RESP);
    assign res_data  = data_q;
    assign res_id    = id_q;
    assign ops_cnt   = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x_q          <= 1'b0;
            y_q          <= 1'b0;
            z_q          <= 1'b0;
            data_q       <= 1'b0;
            id_q         <= '0;
            cnt_q        <= '0;
`ifdef AND_OR_TREE_ARB_RR_EN
            last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        x_q     <= req_x[gnt_id];
                        y_q     <= req_y[gnt_id];
                        z_q     <= req_z[gnt_id];
                        id_q    <= gnt_id;
                        state_q <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    data_q  <= and_or_tree(x_q, y_q, z_q);
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        cnt_q        <= cnt_q + CNT_W'(1);
`ifdef AND_OR_TREE_ARB_RR_EN
                        last_grant_q <= id_q;
`endif
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_or_tree_arbiter.sv
// Bench for and_or_tree_arbiter: vector table, directed corner sequences, random vs. scoreboard.
module tb_and_or_tree_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_ready, req_x, req_y, req_z;
    logic          res_valid, res_ready, res_data;
    logic [IW-1:0] res_id;
    logic [CW-1:0] ops_cnt;

    always #5 clk = ~clk;

    and_or_tree_arbiter #(
        .NUM_REQ (N),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_z     (req_z),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .ops_cnt   (ops_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] x, input logic [3:0] y,
                         input logic [3:0] z, input logic rr);
        req_valid = v;
        req_x     = x;
        req_y     = y;
        req_z     = z;
        res_ready = rr;
    endtask

    task automatic do_reset();
        drive(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset res_valid", 32'(res_valid), 32'd0);
        chk("reset res_id", 32'(res_id), 32'd0);
        chk("reset ops_cnt", 32'(ops_cnt), 32'd0);
        rst = 1'b0;
    endtask

    // Reference arbitration: first valid index after `last` (round-robin) or lowest index.
    function automatic int pick(input logic [3:0] v, input int last);
`ifdef AND_OR_TREE_ARB_RR_EN
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`else
        for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
        return -1;
    endfunction

    typedef struct {
        logic [3:0] v, x, y, z;
        logic       rr;
        logic [3:0] e_rdy;
        logic       e_rv, e_d;
        logic [1:0] e_id;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[15];

    logic [3:0] cx, cy, cz, cf, hold;
    int         g, wid, m_last, m_cnt, m_age, m_id;
    logic       m_busy, m_data, ev;
    logic [3:0] erdy;

    initial begin
        rst = 1'b1;
        drive(4'b0, 4'b0, 4'b0, 4'b0, 1'b0);
        cyc();

        // Single request from 2, then backpressure on requester 1 with 3 pending.
        tbl[0]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 2'd0, 4'd0};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd0};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'd0};
        tbl[3]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 4'd1};
        tbl[4]  = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd1};
        for (int r = 5; r <= 9; r++)
            tbl[r] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 4'd1};
        tbl[10] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'd1};
        tbl[11] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 4'd2};
        tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd2};
        tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 4'd2};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'd3};

        do_reset();
        for (int r = 0; r < 15; r++) begin
            drive(tbl[r].v, tbl[r].x, tbl[r].y, tbl[r].z, tbl[r].rr);
            #1;
            chk($sformatf("tbl%0d req_ready", r), 32'(req_ready), 32'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d res_valid", r), 32'(res_valid), 32'(tbl[r].e_rv));
            chk($sformatf("tbl%0d ops_cnt", r), 32'(ops_cnt), 32'(tbl[r].e_cnt));
            if (tbl[r].e_rv) begin
                chk($sformatf("tbl%0d res_data", r), 32'(res_data), 32'(tbl[r].e_d));
                chk($sformatf("tbl%0d res_id", r), 32'(res_id), 32'(tbl[r].e_id));
            end
            cyc();
        end

        // Contention: all valid, one grant every 3 cycles.
        do_reset();
        cx = 4'b1011; cy = 4'b1101; cz = 4'b0100;
        cf = (cx & cy) | cz;
        drive(4'b1111, cx, cy, cz, 1'b1);
        for (int c = 0; c < 15; c++) begin
`ifdef AND_OR_TREE_ARB_RR_EN
            g = (c / 3) % N;
`else
            g = 0;
`endif
            #1;
            chk($sformatf("cont c%0d req_ready", c), 32'(req_ready),
                (c % 3 == 0) ? (32'd1 << g) : 32'd0);
            chk($sformatf("cont c%0d res_valid", c), 32'(res_valid), (c % 3 == 2) ? 32'd1 : 32'd0);
            if (c % 3 == 2) begin
                chk($sformatf("cont c%0d res_id", c), 32'(res_id), 32'(g));
                chk($sformatf("cont c%0d res_data", c), 32'(res_data), 32'(cf[g]));
            end
            cyc();
        end
        chk("cont ops_cnt", 32'(ops_cnt), 32'd5);

        // Reset while the operation is in EVAL, and reset colliding with a valid request.
        do_reset();
        drive(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1);
        #1;
        chk("mid accept req_ready", 32'(req_ready), 32'b0010);
        cyc();
        rst = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("mid eval res_valid", 32'(res_valid), 32'd0);
        cyc();
        chk("mid post-rst res_valid", 32'(res_valid), 32'd0);
        chk("mid post-rst ops_cnt", 32'(ops_cnt), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mid rst-wins res_valid", 32'(res_valid), 32'd0);
        chk("mid rst-wins req_ready", 32'(req_ready), 32'b0001);
        req_valid = 4'b0011;
        #1;
        chk("mid next grant", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = 4'b0000;
        chk("mid eval2 res_valid", 32'(res_valid), 32'd0);
        cyc();
        chk("mid resp res_valid", 32'(res_valid), 32'd1);
        chk("mid resp res_id", 32'(res_id), 32'd0);
        chk("mid resp res_data", 32'(res_data), 32'd0);
        cyc();
        chk("mid ops_cnt", 32'(ops_cnt), 32'd1);

        // Counter wrap at CNT_W=4: 17 operations leave ops_cnt at 1.
        do_reset();
        drive(4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1);
        for (int c = 0; c <= 51; c++) begin
            #1;
            if (c == 45) chk("wrap cnt15", 32'(ops_cnt), 32'd15);
            if (c == 48) chk("wrap cnt0", 32'(ops_cnt), 32'd0);
            if (c == 51) chk("wrap cnt1", 32'(ops_cnt), 32'd1);
            cyc();
        end

        // Random traffic against a transaction-level scoreboard.
        do_reset();
        hold = '0; m_busy = 1'b0; m_age = 0; m_id = 0; m_data = 1'b0;
        m_last = N - 1; m_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!hold[i]) begin
                    req_valid[i] = ($urandom % 3) == 0;
                    req_x[i] = 1'($urandom);
                    req_y[i] = 1'($urandom);
                    req_z[i] = 1'($urandom);
                    hold[i] = req_valid[i];
                end
            end
            res_ready = ($urandom % 4) != 0;
            #1;
            wid  = pick(req_valid, m_last);
            erdy = (!m_busy && wid >= 0) ? (4'b0001 << wid) : 4'b0000;
            ev   = m_busy && (m_age >= 2);
            chk($sformatf("rnd c%0d req_ready", c), 32'(req_ready), 32'(erdy));
            chk($sformatf("rnd c%0d res_valid", c), 32'(res_valid), 32'(ev));
            chk($sformatf("rnd c%0d ops_cnt", c), 32'(ops_cnt), 32'(m_cnt % 16));
            if (ev) begin
                chk($sformatf("rnd c%0d res_id", c), 32'(res_id), 32'(m_id));
                chk($sformatf("rnd c%0d res_data", c), 32'(res_data), 32'(m_data));
            end
            if (erdy != 0) begin
                m_busy  = 1'b1;
                m_age   = 1;
                m_id    = wid;
                m_data  = (req_x[wid] & req_y[wid]) | req_z[wid];
                hold[wid] = 1'b0;
            end else if (m_busy) begin
                if (ev && res_ready) begin
                    m_busy = 1'b0;
                    m_cnt++;
                    m_last = m_id;
                end else begin
                    m_age++;
                end
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/and_or_tree_arbiter.md
# and_or_tree_arbiter

Shares one registered AND-OR evaluation unit, computing `(x & y) | z`, between `NUM_REQ` requesters. Each requester offers a 3-bit operand set over a valid/ready handshake. The block grants one requester at a time, sequences the operands through capture, evaluate and respond stages, and returns the tagged 1-bit result over a second valid/ready handshake. It sits between the request sources and the shared function/flip-flop datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: requester index width (derived; do not override).
- `CNT_W`, 16: width of the completed-operation counter.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input `NUM_REQ`: per-requester request valid.
- `req_ready` output `NUM_REQ`: per-requester accept; at most one bit set.
- `req_x`, `req_y`, `req_z` input `NUM_REQ`: per-requester operand bits; bit i belongs to requester i.
- `res_valid` output 1: result available.
- `res_ready` input 1: downstream accepts the result.
- `res_data` output 1: result, `(x & y) | z` of the granted operands.
- `res_id` output `ID_W`: index of the requester that produced `res_data`.
- `ops_cnt` output `CNT_W`: count of completed result handshakes.

## Operation
- The FSM has three states: IDLE, EVAL and RESP.
- **IDLE**
  - If any `req_valid` bit is set, the winner is picked combinationally and `req_ready[winner]` is driven to 1.
  - On that edge the block captures `req_x/y/z[winner]`, stores `winner` into the id register and moves to EVAL.
  - If no `req_valid` bit is set, the FSM stays in IDLE.
- **EVAL**
  - The result register loads `(x & y) | z` from the captured operands.
  - The FSM moves to RESP unconditionally.
- **RESP**
  - `res_valid` is 1.
  - `res_data` and `res_id` are held stable until `res_valid & res_ready`.
  - On that handshake: `ops_cnt` increments (wraps modulo 2^CNT_W), the arbitration pointer updates, and the FSM returns to IDLE.
- `req_ready` is all-zero outside IDLE.
- Requesters must hold `req_valid` and operands until accepted; a withdrawn request is simply not granted.
- **Arbitration**
  - Round-robin: search starts at `(last_grant + 1) mod NUM_REQ`.
  - The pointer updates only on result handshake completion, not on capture.
- **Reset values:** state IDLE, `req_ready` 0, `res_valid` 0, `res_data` 0, `res_id` 0, `ops_cnt` 0, `last_grant` = NUM_REQ-1 (so requester 0 wins first).

## Timing
- Request accepted on edge N (IDLE, `req_valid[i] & req_ready[i]`).
- Result registered on edge N+1.
- `res_valid` goes high after edge N+1 and is first sampled on edge N+2.
- Minimum accept-to-result latency is 2 cycles.
- Minimum issue interval is 3 cycles, with `res_ready` tied high.
- `res_ready` stuck low: the FSM stays in RESP indefinitely and no new request is accepted.
- Reset during EVAL or RESP: in-flight operation discarded with no result emitted; `ops_cnt` cleared; all outputs at reset values the cycle after the reset edge.
- `req_valid` and `rst` asserted together: reset wins and nothing is captured.
- Single active requester: it is re-granted each time it requests (the pointer wraps to it).
- `ops_cnt` at all-ones plus one handshake: wraps to 0.

## Configuration
- Macro: `AND_OR_TREE_ARB_RR_EN`.
- Defined: round-robin arbitration as described above.
- Undefined:
  - Fixed priority; the lowest index with `req_valid` set wins.
  - The `last_grant` register is not instantiated.
  - Starvation of high indices is permitted.
  - All other behaviour and timing are identical.

## Structure
- Package `and_or_tree_arb_pkg` holds:
  - `typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_RESP} arb_state_t`.
  - The `and_or_tree` function, `(x & y) | z`, shared with the datapath.
  - Constant `AOT_ARB_MAX_REQ = 16`.
- Sub-module `aot_rr_pick`:
  - Combinational one-hot/index picker.
  - Inputs: `req` vector and start pointer.
  - Outputs: `gnt_onehot`, `gnt_id`, `any`.
  - Contains the fixed-priority path selected by the macro.

## Test plan
- **Reset:** assert `rst` 2 cycles. Expect `req_ready`=0000, `res_valid`=0, `res_id`=0, `ops_cnt`=0.
- **Single request:** requester 2 with x=1, y=1, z=0.
  - `req_ready`=0100 in cycle 0.
  - `res_valid`=1 at cycle 2 with `res_data`=1, `res_id`=2.
  - `ops_cnt`=1 after the handshake.
- **Contention:** all four requesters continuously valid, `res_ready`=1.
  - Grant order 0,1,2,3,0 (round-robin), one grant every 3 cycles.
  - Results match `(x&y)|z` for each requester.
  - Without the macro: grants 0,0,0,0.
- **Backpressure:** `res_ready`=0 for 5 cycles in RESP.
  - `res_valid`, `res_data` and `res_id` stay stable.
  - `req_ready` stays 0000 despite pending requests.
  - Release: handshake, then the next grant the following cycle.
- **Reset mid-flight:** accept x=0, y=0, z=1, then assert `rst` in EVAL.
  - No `res_valid` pulse; `ops_cnt`=0.
  - Requester 0 wins the next arbitration.
- **Counter wrap:** `CNT_W`=4, complete 17 operations; expect `ops_cnt`=1.
